efuse_pgm_seq: RTL and testbench
================================

Name: efuse_pgm_seq

Overview:
- Program-timing sequencer behind the efuse read/write controller's write path.
- Accepts one write request (word select, NW-bit data, password) and walks the word bit by bit.
- For every bit set to 1, drives the efuse macro program pins (pgenb, strobe, addr) with parameterised setup, program-pulse and hold timing.
- Returns write_done, efuse_busy_write and an error flag to the controller.

Parameters:
- NW, 64, bits per write word; 256/NW words in the 256-bit array.
- T_SETUP, 4, cycles pgenb low with addr stable before strobe rises (>=1).
- T_PGM, 100, strobe high width in cycles (>=1).
- T_HOLD, 4, cycles pgenb low after strobe falls (>=1).
- PASSWORD, 16'hA5C3, required value of rg_efuse_password.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- write_start  input  1  one-cycle request pulse from the controller.
- write_sel  input  $clog2(256/NW)  target word index.
- write_data  input  NW  bits to blow; 1 = program.
- rg_efuse_password  input  16  unlock key, sampled with write_start.
- write_done  output  1  one-cycle completion pulse.
- efuse_busy_write  output  1  high while not IDLE.
- write_err  output  1  password mismatch on the last request; sticky.
- efuse_pgenb  output  1  macro program enable, active low.
- efuse_strobe  output  1  macro program strobe.
- efuse_addr  output  8  bit address = write_sel*NW + bit_idx.

Behaviour:
- Reset values: write_done=0, efuse_busy_write=0, write_err=0, efuse_pgenb=1, efuse_strobe=0, efuse_addr=0; state=IDLE, bit_idx=0, timer=0.
- All outputs are registered, except efuse_busy_write, which is decoded from the state register.
- States and transitions:
  - IDLE: on write_start, latch sel/data/password, clear write_err, go to CHECK. write_start in any other state is ignored; nothing is latched.
  - CHECK (1 cycle): password != PASSWORD -> set write_err, go to DONE. Otherwise bit_idx=0; go to SETUP if data[0]=1, else NEXT.
  - SETUP: pgenb=0, addr valid; T_SETUP cycles, then STROBE.
  - STROBE: strobe=1, pgenb=0; T_PGM cycles, then HOLD.
  - HOLD: strobe=0, pgenb=0; T_HOLD cycles, then NEXT.
  - NEXT (1 cycle): pgenb=1. If bit_idx==NW-1 go to DONE. Otherwise increment bit_idx and go to SETUP if data[bit_idx+1]=1, else NEXT.
  - DONE (1 cycle): write_done=1, then IDLE.
- Down-counter timer is sized for max(T_SETUP,T_PGM,T_HOLD); it is reloaded on each state entry.
- efuse_addr updates on entry to SETUP and holds constant through SETUP/STROBE/HOLD. It must never change while pgenb=0.
- strobe is high only when pgenb is low; the two never toggle on the same edge.
- Latency (skip build), measured from the accepting edge to write_done high: 1 + ones*(T_SETUP+T_PGM+T_HOLD+1) + zeros.
- Password failure: write_done 1 edge after the accepting edge; no strobe or pgenb activity.
- All-zero data: NW NEXT cycles, no strobe, write_err=0.
- Reset mid-operation: strobe and pgenb return to idle values immediately (asynchronously); the in-flight request is dropped and write_done is not issued.
- write_err stays set until the next accepted write_start.

Optional Feature:
- Macro EFUSE_PGM_SKIP_ZERO_EN.
- Defined: zero bits cost one NEXT cycle only (behaviour described above).
- Undefined: every bit walks SETUP/STROBE/HOLD/NEXT with full timing.
  - For zero bits, pgenb stays 1 and strobe stays 0.
  - Latency becomes 1 + NW*(T_SETUP+T_PGM+T_HOLD+1), independent of data.

Test Plan:
- Defaults, skip build; write_sel=2, write_data=64'h1, correct password -> one strobe pulse of exactly 100 cycles with addr=128; pgenb low for 108 cycles; write_done one cycle at edge 173 after accept; write_err=0.
- write_data=64'h8000_0000_0000_0001, write_sel=3 -> two strobes at addr 192 then 255; addr stable while pgenb=0; write_done at edge 1+2*109+62=281.
- Password 16'h0000 -> write_done at edge 1, write_err=1, pgenb stays 1, strobe stays 0. Next accepted request with the correct password clears write_err.
- write_start pulses during STROBE with different sel/data -> ignored; original programming completes unchanged; efuse_busy_write high throughout.
- rst_n asserted mid-STROBE -> strobe=0, pgenb=1, busy=0 immediately; no write_done after release; a new request then runs normally.
- No-skip build, write_data=0 -> zero strobes, pgenb constantly 1, write_done at edge 1+64*109=6977.

Source files
------------

// File: rtl/efuse_pgm_seq.sv
// efuse_pgm_seq: program-timing sequencer for the efuse write path.
// Walks one NW-bit word bit by bit and drives pgenb/strobe/addr with
// T_SETUP / T_PGM / T_HOLD timing for every bit that must be blown.
// Build option: define EFUSE_PGM_SKIP_ZERO_EN to let zero bits cost a single
// NEXT cycle; left undefined, every bit walks the full timing window with
// pgenb/strobe kept idle for zero bits (data-independent latency).
module efuse_pgm_seq #(
   parameter int unsigned NW       = 64,
   parameter int unsigned T_SETUP  = 4,
   parameter int unsigned T_PGM    = 100,
   parameter int unsigned T_HOLD   = 4,
   parameter logic [15:0] PASSWORD = 16'hA5C3,
   localparam int unsigned NWORDS  = 256 / NW,
   localparam int unsigned SEL_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             write_start,
   input  logic [SEL_W-1:0] write_sel,
   input  logic [NW-1:0]    write_data,
   input  logic [15:0]      rg_efuse_password,
   output logic             write_done,
   output logic             efuse_busy_write,
   output logic             write_err,
   output logic             efuse_pgenb,
   output logic             efuse_strobe,
   output logic [7:0]       efuse_addr
);

   localparam int unsigned BIT_W = (NW > 1) ? $clog2(NW) : 1;
   localparam int unsigned T_MAX = (T_SETUP > T_PGM) ?
                                   ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD) :
                                   ((T_PGM > T_HOLD) ? T_PGM : T_HOLD);
   localparam int unsigned TMR_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(T_SETUP - 1);
   localparam logic [TMR_W-1:0] TMR_PGM   = TMR_W'(T_PGM - 1);
   localparam logic [TMR_W-1:0] TMR_HOLD  = TMR_W'(T_HOLD - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NW - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_SETUP  = 3'd2,
      S_STROBE = 3'd3,
      S_HOLD   = 3'd4,
      S_NEXT   = 3'd5,
      S_DONE   = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [NW-1:0]      data_q, data_d;
   logic [15:0]        pwd_q, pwd_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               pgenb_q, pgenb_d;
   logic               strobe_q, strobe_d;
   logic [7:0]         addr_q, addr_d;
   logic               enter_bit;
   logic               pgm_bit;
   logic               in_window;

   // Next-state, timer and registered-output decode
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      data_d    = data_q;
      pwd_d     = pwd_q;
      bit_d     = bit_q;
      tmr_d     = tmr_q;
      err_d     = err_q;
      addr_d    = addr_q;
      enter_bit = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (write_start) begin
               sel_d   = write_sel;
               data_d  = write_data;
               pwd_d   = rg_efuse_password;
               err_d   = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (pwd_q != PASSWORD) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               bit_d     = '0;
               enter_bit = 1'b1;
            end
         end
         S_SETUP: begin
            if (tmr_q == '0) state_d = S_STROBE;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         S_STROBE: begin
            if (tmr_q == '0) state_d = S_HOLD;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         S_HOLD: begin
            if (tmr_q == '0) state_d = S_NEXT;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         S_NEXT: begin
            if (bit_q == LAST_BIT) begin
               state_d = S_DONE;
            end else begin
               bit_d     = bit_q + BIT_W'(1);
               enter_bit = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Choose where the next bit starts its walk
      if (enter_bit) begin
`ifdef EFUSE_PGM_SKIP_ZERO_EN
         state_d = data_q[bit_d] ? S_SETUP : S_NEXT;
`else
         state_d = S_SETUP;
`endif
      end

      // Reload the down-counter on every state entry
      if ((state_d != state_q) || enter_bit) begin
         case (state_d)
            S_SETUP:  tmr_d = TMR_SETUP;
            S_STROBE: tmr_d = TMR_PGM;
            S_HOLD:   tmr_d = TMR_HOLD;
            default:  tmr_d = '0;
         endcase
      end

      // Address moves only when a new SETUP window opens (pgenb still high)
      if ((state_d == S_SETUP) && (state_q != S_SETUP)) begin
         addr_d = 8'((32'(sel_q) * NW) + 32'(bit_d));
      end

      pgm_bit   = data_q[bit_d];
      in_window = (state_d == S_SETUP) || (state_d == S_STROBE) ||
                  (state_d == S_HOLD);
      pgenb_d   = ~(in_window && pgm_bit);
      strobe_d  = (state_d == S_STROBE) && pgm_bit;
      done_d    = (state_d == S_DONE);
   end

   // State and output registers; reset returns macro pins to idle at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         data_q   <= '0;
         pwd_q    <= '0;
         bit_q    <= '0;
         tmr_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         pgenb_q  <= 1'b1;
         strobe_q <= 1'b0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         data_q   <= data_d;
         pwd_q    <= pwd_d;
         bit_q    <= bit_d;
         tmr_q    <= tmr_d;
         done_q   <= done_d;
         err_q    <= err_d;
         pgenb_q  <= pgenb_d;
         strobe_q <= strobe_d;
         addr_q   <= addr_d;
      end
   end

   assign efuse_busy_write = (state_q != S_IDLE);
   assign write_done       = done_q;
   assign write_err        = err_q;
   assign efuse_pgenb      = pgenb_q;
   assign efuse_strobe     = strobe_q;
   assign efuse_addr       = addr_q;

endmodule

// File: tb/tb_efuse_pgm_seq.sv
// Testbench for efuse_pgm_seq: vector table, random requests against a
// behavioural model, ignored-request and mid-operation reset sequences.
module tb_efuse_pgm_seq;

   localparam int unsigned NW      = 64;
   localparam int unsigned T_SETUP = 4;
   localparam int unsigned T_PGM   = 100;
   localparam int unsigned T_HOLD  = 4;
   localparam logic [15:0] PWD     = 16'hA5C3;
   localparam int          SW      = 2;
   localparam int          PER_BIT = T_SETUP + T_PGM + T_HOLD + 1;

`ifdef EFUSE_PGM_SKIP_ZERO_EN
   localparam int L_ONE = 173;
   localparam int L_TWO = 281;
   localparam int L_ZER = 65;
`else
   localparam int L_ONE = 6977;
   localparam int L_TWO = 6977;
   localparam int L_ZER = 6977;
`endif

   logic          clk;
   logic          rst_n;
   logic          write_start;
   logic [SW-1:0] write_sel;
   logic [NW-1:0] write_data;
   logic [15:0]   rg_efuse_password;
   logic          write_done;
   logic          efuse_busy_write;
   logic          write_err;
   logic          efuse_pgenb;
   logic          efuse_strobe;
   logic [7:0]    efuse_addr;

   int total = 0;
   int bad   = 0;
   logic last_err;

   efuse_pgm_seq #(
      .NW(NW), .T_SETUP(T_SETUP), .T_PGM(T_PGM), .T_HOLD(T_HOLD), .PASSWORD(PWD)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .write_start       (write_start),
      .write_sel         (write_sel),
      .write_data        (write_data),
      .rg_efuse_password (rg_efuse_password),
      .write_done        (write_done),
      .efuse_busy_write  (efuse_busy_write),
      .write_err         (write_err),
      .efuse_pgenb       (efuse_pgenb),
      .efuse_strobe      (efuse_strobe),
      .efuse_addr        (efuse_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: latency from the accepting edge to write_done
   function automatic int model_lat(input logic [NW-1:0] d, input logic [15:0] p);
      int ones;
      if (p != PWD) return 1;
      ones = $countones(d);
`ifdef EFUSE_PGM_SKIP_ZERO_EN
      return 1 + ones * PER_BIT + (NW - ones);
`else
      return 1 + NW * PER_BIT;
`endif
   endfunction

   // Issue one request and watch the macro pins until write_done
   task automatic run_write(input string tag, input logic [SW-1:0] sel,
                            input logic [NW-1:0] data, input logic [15:0] pwd,
                            input int exp_lat, input logic exp_err,
                            input int exp_nstr, input int inj_n);
      int   exp_addr[$];
      int   got_addr[$];
      int   got_w[$];
      int   got_span[$];
      int   n, done_at, strw, spw;
      int   v_ovl, v_tog, v_addr, busy_bad;
      logic prev_p, prev_s;
      logic [7:0] prev_a;

      if (pwd == PWD)
         for (int i = 0; i < int'(NW); i++)
            if (data[i]) exp_addr.push_back(int'(sel) * int'(NW) + i);

      chk({tag, " err_before"}, 64'(write_err), 64'(last_err));
      write_sel = sel; write_data = data; rg_efuse_password = pwd;
      write_start = 1'b1;
      @(posedge clk); #1;
      write_start = 1'b0;
      write_sel = SW'($urandom); write_data = {$urandom, $urandom};
      rg_efuse_password = 16'($urandom);

      prev_p = efuse_pgenb; prev_s = efuse_strobe; prev_a = efuse_addr;
      n = 0; done_at = -1; strw = 0; spw = 0;
      v_ovl = 0; v_tog = 0; v_addr = 0; busy_bad = 0;
      while (done_at < 0 && n < exp_lat + 50) begin
         if (n == inj_n) begin
            write_start = 1'b1; write_sel = ~sel; write_data = ~data;
            rg_efuse_password = PWD;
         end
         @(posedge clk); #1;
         write_start = 1'b0;
         n++;
         if (efuse_strobe && efuse_pgenb) v_ovl++;
         if ((efuse_strobe !== prev_s) && (efuse_pgenb !== prev_p)) v_tog++;
         if (!efuse_pgenb && !prev_p && (efuse_addr !== prev_a)) v_addr++;
         if (!efuse_busy_write) busy_bad++;
         if (efuse_strobe && !prev_s) begin got_addr.push_back(int'(efuse_addr)); strw = 0; end
         if (efuse_strobe) strw++;
         if (!efuse_strobe && prev_s) got_w.push_back(strw);
         if (!efuse_pgenb) spw++;
         if (efuse_pgenb && !prev_p) begin got_span.push_back(spw); spw = 0; end
         if (write_done) done_at = n;
         prev_p = efuse_pgenb; prev_s = efuse_strobe; prev_a = efuse_addr;
      end

      chk({tag, " done_seen"}, 64'(done_at >= 0), 64'd1);
      chk({tag, " latency"}, 64'(done_at), 64'(exp_lat));
      chk({tag, " err"}, 64'(write_err), 64'(exp_err));
      chk({tag, " busy_held"}, 64'(busy_bad), 64'd0);
      chk({tag, " strobe_w_pgenb"}, 64'(v_ovl), 64'd0);
      chk({tag, " same_edge"}, 64'(v_tog), 64'd0);
      chk({tag, " addr_stable"}, 64'(v_addr), 64'd0);
      chk({tag, " nstrobe"}, 64'(got_addr.size()), 64'(exp_nstr));
      chk({tag, " nstrobe_model"}, 64'(got_addr.size()), 64'(exp_addr.size()));
      chk({tag, " nspan"}, 64'(got_span.size()), 64'(exp_addr.size()));
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
         chk($sformatf("%s addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      for (int i = 0; i < got_w.size(); i++)
         chk($sformatf("%s strobe_w%0d", tag, i), 64'(got_w[i]), 64'(T_PGM));
      for (int i = 0; i < got_span.size(); i++)
         chk($sformatf("%s pgenb_w%0d", tag, i), 64'(got_span[i]),
             64'(T_SETUP + T_PGM + T_HOLD));
      @(posedge clk); #1;
      chk({tag, " done_1cyc"}, 64'(write_done), 64'd0);
      chk({tag, " busy_after"}, 64'(efuse_busy_write), 64'd0);
      last_err = exp_err;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, " err_sticky"}, 64'(write_err), 64'(exp_err));
   endtask

   typedef struct {
      logic [SW-1:0] sel;
      logic [NW-1:0] data;
      logic [15:0]   pwd;
      logic          exp_err;
      int            exp_nstr;
      int            exp_lat;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [SW-1:0] rs;
      logic [NW-1:0] rd;
      logic [15:0]   rp;
      int            n;
      logic          seen;

      vecs[0] = '{2'd2, 64'h1,                  PWD,      1'b0, 1, L_ONE};
      vecs[1] = '{2'd3, 64'h8000_0000_0000_0001, PWD,      1'b0, 2, L_TWO};
      vecs[2] = '{2'd0, 64'hFFFF,               16'h0000, 1'b1, 0, 1};
      vecs[3] = '{2'd1, 64'h0,                  PWD,      1'b0, 0, L_ZER};
      vecs[4] = '{2'd0, 64'h5,                  16'hA5C2, 1'b1, 0, 1};

      rst_n = 1'b0; write_start = 1'b0; write_sel = '0; write_data = '0;
      rg_efuse_password = '0; last_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst done", 64'(write_done), 64'd0);
      chk("rst busy", 64'(efuse_busy_write), 64'd0);
      chk("rst err", 64'(write_err), 64'd0);
      chk("rst pgenb", 64'(efuse_pgenb), 64'd1);
      chk("rst strobe", 64'(efuse_strobe), 64'd0);
      chk("rst addr", 64'(efuse_addr), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++)
         run_write($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].pwd,
                   vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_nstr, -1);

      for (int r = 0; r < 5; r++) begin
         rs = SW'($urandom);
         rd = {$urandom, $urandom};
         if (r < 2) rp = PWD;
         else begin
            rp = 16'($urandom);
            if (rp == PWD) rp = rp ^ 16'h1;
         end
         run_write($sformatf("rand%0d", r), rs, rd, rp, model_lat(rd, rp),
                   rp != PWD, (rp == PWD) ? $countones(rd) : 0, -1);
      end

      // A request arriving mid-STROBE must be dropped without effect
      run_write("ignore", 2'd2, 64'h1, PWD, L_ONE, 1'b0, 1, 50);

      // Reset during STROBE: pins go idle at once, no write_done afterwards
      write_sel = 2'd0; write_data = 64'h1; rg_efuse_password = PWD;
      write_start = 1'b1;
      @(posedge clk); #1;
      write_start = 1'b0;
      n = 0;
      while (!efuse_strobe && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_mid reached_strobe", 64'(efuse_strobe), 64'd1);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_mid strobe", 64'(efuse_strobe), 64'd0);
      chk("rst_mid pgenb", 64'(efuse_pgenb), 64'd1);
      chk("rst_mid busy", 64'(efuse_busy_write), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      last_err = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #1;
         if (write_done || efuse_strobe || !efuse_pgenb || efuse_busy_write) seen = 1'b1;
      end
      chk("rst_mid quiet_after", 64'(seen), 64'd0);
      run_write("post_rst", 2'd1, 64'h2, PWD, model_lat(64'h2, PWD), 1'b0, 1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
